// File: rtl/regfile_sb.sv
// Register file with two combinational read ports, one write port, a hardwired zero
// register and a per-register pending-write scoreboard. Optional: REGFILE_SB_BYPASS_EN.
module regfile_sb #(
    parameter int WIDTH    = 64,
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = DEPTH - 1,
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    output logic             busy1,
    output logic             busy2,
    input  logic             we3,
    input  logic [AW-1:0]    wa3,
    input  logic [WIDTH-1:0] wd3,
    input  logic             iss_v,
    input  logic [AW-1:0]    iss_a,
    output logic             iss_stall,
    output logic [AW:0]      pending_cnt
);

    localparam logic [AW-1:0] ZA = AW'(ZERO_REG);

    logic [WIDTH-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0] r_busy;
    logic [AW:0]      r_pending;

    logic             w_wr;
    logic             w_clr;
    logic             w_iss_acc;
    logic             w_iss_stall;
    logic [DEPTH-1:0] w_busy_nxt;
    logic [AW:0]      w_pend_nxt;

    assign w_wr        = we3 && (wa3 != ZA);
    assign w_clr       = w_wr && r_busy[wa3];
    // WAW guard looks only at the current busy state, never at a same-cycle write.
    assign w_iss_stall = iss_v && (iss_a != ZA) && r_busy[iss_a];
    assign w_iss_acc   = iss_v && !w_iss_stall && (iss_a != ZA);

    assign iss_stall   = w_iss_stall;
    assign pending_cnt = r_pending;

    // Clear before set so a write and an issue to the same register leave it reserved.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wr)
            w_busy_nxt[wa3] = 1'b0;
        if (w_iss_acc)
            w_busy_nxt[iss_a] = 1'b1;
        w_pend_nxt = r_pending + (AW+1)'(w_iss_acc) - (AW+1)'(w_clr);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                r_regs[i] <= WIDTH'(i);
            r_busy    <= '0;
            r_pending <= '0;
        end else begin
            if (w_wr)
                r_regs[wa3] <= wd3;
            r_busy    <= w_busy_nxt;
            r_pending <= w_pend_nxt;
        end
    end

    always_comb begin
        rd1   = r_regs[ra1];
        busy1 = r_busy[ra1];
`ifdef REGFILE_SB_BYPASS_EN
        if (w_wr && (wa3 == ra1)) begin
            rd1   = wd3;
            busy1 = 1'b0;
        end
`endif
        if (ra1 == ZA) begin
            rd1   = '0;
            busy1 = 1'b0;
        end
    end

    always_comb begin
        rd2   = r_regs[ra2];
        busy2 = r_busy[ra2];
`ifdef REGFILE_SB_BYPASS_EN
        if (w_wr && (wa3 == ra2)) begin
            rd2   = wd3;
            busy2 = 1'b0;
        end
`endif
        if (ra2 == ZA) begin
            rd2   = '0;
            busy2 = 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (default 64x32, zero register 31);
// expectations adapt to REGFILE_SB_BYPASS_EN.
module tb_regfile_sb;

    localparam int WIDTH = 64;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
`ifdef REGFILE_SB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clk;
    logic             reset_n;
    logic [AW-1:0]    ra1, ra2, wa3, iss_a;
    logic [WIDTH-1:0] rd1, rd2, wd3;
    logic             busy1, busy2, we3, iss_v, iss_stall;
    logic [AW:0]      pending_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_sb #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(DEPTH-1)) dut (
        .clk(clk), .reset_n(reset_n),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .busy1(busy1), .busy2(busy2),
        .we3(we3), .wa3(wa3), .wd3(wd3),
        .iss_v(iss_v), .iss_a(iss_a), .iss_stall(iss_stall),
        .pending_cnt(pending_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [WIDTH-1:0] exp1, exp2;
        reset_n = 1'b0;
        we3 = 1'b0; wa3 = '0; wd3 = '0; iss_v = 1'b0; iss_a = '0; ra1 = '0; ra2 = '0;
        step(); step();
        #2 reset_n = 1'b1;
        step();
        for (int i = 0; i < DEPTH; i++) begin
            ra1 = AW'(i);
            ra2 = AW'(DEPTH - 1 - i);
            #1;
            exp1 = (i == DEPTH - 1) ? 64'd0 : 64'(i);
            exp2 = (i == 0) ? 64'd0 : 64'(DEPTH - 1 - i);
            n_checks++;
            if (rd1 !== exp1 || busy1 !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_rd1[%0d]: got rd1=%h busy1=%b, want rd1=%h busy1=0", i, rd1, busy1, exp1);
            end
            n_checks++;
            if (rd2 !== exp2 || busy2 !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_rd2[%0d]: got rd2=%h busy2=%b, want rd2=%h busy2=0", DEPTH-1-i, rd2, busy2, exp2);
            end
        end
        n_checks++;
        if (pending_cnt !== 6'd0 || iss_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_cnt: got pending_cnt=%0d iss_stall=%b, want 0 and 0", pending_cnt, iss_stall);
        end
    endtask

    task automatic test_zero_reg();
        we3 = 1'b1; wa3 = 5'd31; wd3 = 64'hDEAD_BEEF;
        step();
        we3 = 1'b0;
        ra1 = 5'd31;
        #1;
        n_checks++;
        if (rd1 !== 64'd0 || busy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_write: got rd1=%h busy1=%b, want 0 and 0", rd1, busy1);
        end
        iss_v = 1'b1; iss_a = 5'd31;
        #1;
        n_checks++;
        if (iss_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_issue_stall: got iss_stall=%b, want 0", iss_stall);
        end
        step();
        iss_v = 1'b0;
        #1;
        n_checks++;
        if (pending_cnt !== 6'd0 || busy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_issue_cnt: got pending_cnt=%0d busy1=%b, want 0 and 0", pending_cnt, busy1);
        end
    endtask

    task automatic test_issue_write();
        iss_v = 1'b1; iss_a = 5'd5;
        step();
        iss_v = 1'b0;
        ra1 = 5'd5;
        #1;
        n_checks++;
        if (busy1 !== 1'b1 || pending_cnt !== 6'd1 || rd1 !== 64'd5) begin
            n_fail++;
            $display("FAIL issue_x5: got busy1=%b cnt=%0d rd1=%h, want 1, 1, 5", busy1, pending_cnt, rd1);
        end
        we3 = 1'b1; wa3 = 5'd5; wd3 = 64'h1234;
        #1;
        n_checks++;
        if (rd1 !== (BYP ? 64'h1234 : 64'd5) || busy1 !== !BYP) begin
            n_fail++;
            $display("FAIL write_x5_same_cycle: got rd1=%h busy1=%b, want %h %b",
                     rd1, busy1, BYP ? 64'h1234 : 64'd5, !BYP);
        end
        step();
        we3 = 1'b0;
        #1;
        n_checks++;
        if (busy1 !== 1'b0 || rd1 !== 64'h1234 || pending_cnt !== 6'd0) begin
            n_fail++;
            $display("FAIL write_x5_after: got busy1=%b rd1=%h cnt=%0d, want 0, 1234, 0", busy1, rd1, pending_cnt);
        end
    endtask

    task automatic test_waw_stall();
        iss_v = 1'b1; iss_a = 5'd7;
        #1;
        n_checks++;
        if (iss_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL waw_first: got iss_stall=%b, want 0", iss_stall);
        end
        step();
        n_checks++;
        if (iss_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL waw_second: got iss_stall=%b, want 1", iss_stall);
        end
        step();
        iss_v = 1'b0;
        #1;
        n_checks++;
        if (pending_cnt !== 6'd1) begin
            n_fail++;
            $display("FAIL waw_cnt: got pending_cnt=%0d, want 1", pending_cnt);
        end
    endtask

    task automatic test_move();
        iss_v = 1'b1; iss_a = 5'd3;
        step();
        we3 = 1'b1; wa3 = 5'd3; wd3 = 64'h33;
        iss_a = 5'd4;
        #1;
        n_checks++;
        if (iss_stall !== 1'b0 || pending_cnt !== 6'd2) begin
            n_fail++;
            $display("FAIL move_pre: got iss_stall=%b cnt=%0d, want 0, 2", iss_stall, pending_cnt);
        end
        step();
        we3 = 1'b0; iss_v = 1'b0;
        ra1 = 5'd3; ra2 = 5'd4;
        #1;
        n_checks++;
        if (busy1 !== 1'b0 || busy2 !== 1'b1 || pending_cnt !== 6'd2 || rd1 !== 64'h33) begin
            n_fail++;
            $display("FAIL move_post: got busy3=%b busy4=%b cnt=%0d rd3=%h, want 0, 1, 2, 33",
                     busy1, busy2, pending_cnt, rd1);
        end
    endtask

    task automatic test_write_vs_stall();
        we3 = 1'b1; wa3 = 5'd7; wd3 = 64'h77;
        iss_v = 1'b1; iss_a = 5'd7;
        ra1 = 5'd7;
        #1;
        n_checks++;
        if (iss_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL wstall_stall: got iss_stall=%b, want 1", iss_stall);
        end
        step();
        we3 = 1'b0;
        #1;
        n_checks++;
        if (busy1 !== 1'b0 || pending_cnt !== 6'd1 || iss_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL wstall_post: got busy7=%b cnt=%0d iss_stall=%b, want 0, 1, 0", busy1, pending_cnt, iss_stall);
        end
        step();
        iss_v = 1'b0;
        #1;
        n_checks++;
        if (busy1 !== 1'b1 || pending_cnt !== 6'd2 || rd1 !== 64'h77) begin
            n_fail++;
            $display("FAIL wstall_retry: got busy7=%b cnt=%0d rd7=%h, want 1, 2, 77", busy1, pending_cnt, rd1);
        end
    endtask

    task automatic test_back_to_back();
        we3 = 1'b1; wa3 = 5'd10; wd3 = 64'hABC;
        iss_v = 1'b1; iss_a = 5'd10;
        #1;
        n_checks++;
        if (iss_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL same_reg_stall: got iss_stall=%b, want 0", iss_stall);
        end
        step();
        iss_v = 1'b0;
        wa3 = 5'd11; wd3 = 64'hBBB;
        ra1 = 5'd10; ra2 = 5'd12;
        #1;
        n_checks++;
        if (busy1 !== 1'b1 || rd1 !== 64'hABC || pending_cnt !== 6'd3) begin
            n_fail++;
            $display("FAIL same_reg_post: got busy10=%b rd10=%h cnt=%0d, want 1, abc, 3", busy1, rd1, pending_cnt);
        end
        step();
        we3 = 1'b0;
        ra2 = 5'd11;
        #1;
        n_checks++;
        if (rd2 !== 64'hBBB || busy2 !== 1'b0 || pending_cnt !== 6'd3) begin
            n_fail++;
            $display("FAIL idle_write: got rd11=%h busy11=%b cnt=%0d, want bbb, 0, 3", rd2, busy2, pending_cnt);
        end
    endtask

    task automatic test_bypass();
        ra1 = 5'd9; ra2 = 5'd9;
        we3 = 1'b1; wa3 = 5'd9; wd3 = 64'hAA;
        #1;
        n_checks++;
        if (rd1 !== (BYP ? 64'hAA : 64'd9) || rd2 !== (BYP ? 64'hAA : 64'd9)) begin
            n_fail++;
            $display("FAIL bypass_same_cycle: got rd1=%h rd2=%h, want %h", rd1, rd2, BYP ? 64'hAA : 64'd9);
        end
        step();
        we3 = 1'b0;
        #1;
        n_checks++;
        if (rd1 !== 64'hAA || rd2 !== 64'hAA) begin
            n_fail++;
            $display("FAIL bypass_next_cycle: got rd1=%h rd2=%h, want aa", rd1, rd2);
        end
    endtask

    task automatic test_mid_reset();
        iss_v = 1'b1;
        iss_a = 5'd1; step();
        iss_a = 5'd2; step();
        iss_a = 5'd3; step();
        iss_v = 1'b0;
        ra1 = 5'd2; ra2 = 5'd3;
        #1;
        n_checks++;
        if (pending_cnt !== 6'd6 || busy1 !== 1'b1 || busy2 !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset: got cnt=%0d busy2=%b busy3=%b, want 6, 1, 1", pending_cnt, busy1, busy2);
        end
        #1 reset_n = 1'b0;
        #1;
        n_checks++;
        if (pending_cnt !== 6'd0 || busy1 !== 1'b0 || busy2 !== 1'b0 || rd1 !== 64'd2 || rd2 !== 64'd3) begin
            n_fail++;
            $display("FAIL async_reset: got cnt=%0d busy2=%b busy3=%b rd2=%h rd3=%h, want 0, 0, 0, 2, 3",
                     pending_cnt, busy1, busy2, rd1, rd2);
        end
        we3 = 1'b1; wa3 = 5'd2; wd3 = 64'hFF;
        iss_v = 1'b1; iss_a = 5'd3;
        step();
        we3 = 1'b0; iss_v = 1'b0;
        #1;
        n_checks++;
        if (rd1 !== 64'd2 || busy2 !== 1'b0 || pending_cnt !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_edge_lost: got rd2=%h busy3=%b cnt=%0d, want 2, 0, 0", rd1, busy2, pending_cnt);
        end
        reset_n = 1'b1;
        we3 = 1'b1; wa3 = 5'd2; wd3 = 64'h55;
        iss_v = 1'b1; iss_a = 5'd3;
        step();
        we3 = 1'b0; iss_v = 1'b0;
        #1;
        n_checks++;
        if (rd1 !== 64'h55 || busy2 !== 1'b1 || pending_cnt !== 6'd1) begin
            n_fail++;
            $display("FAIL first_after_reset: got rd2=%h busy3=%b cnt=%0d, want 55, 1, 1", rd1, busy2, pending_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_zero_reg();
        test_issue_write();
        test_waw_stall();
        test_move();
        test_write_vs_stall();
        test_back_to_back();
        test_bypass();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
